// File: rtl/fft8_bfly_twiddle_if.sv
// Sample/result bundle for the radix-2 twiddle butterfly.
// The master drives operands and control; the slave returns results and flags.
interface fft8_bfly_twiddle_if #(
  parameter int W = 16
);
  logic                en;
  logic                in_valid;
  logic [1:0]          k;
  logic signed [W-1:0] a_re;
  logic signed [W-1:0] a_im;
  logic signed [W-1:0] b_re;
  logic signed [W-1:0] b_im;
  logic                ovf_clr;
  logic                out_valid;
  logic signed [W-1:0] sum_re;
  logic signed [W-1:0] sum_im;
  logic signed [W-1:0] dif_re;
  logic signed [W-1:0] dif_im;
  logic                sat;
  logic                ovf_sticky;

  modport master (
    output en, in_valid, k, a_re, a_im, b_re, b_im, ovf_clr,
    input  out_valid, sum_re, sum_im, dif_re, dif_im, sat, ovf_sticky
  );

  modport slave (
    input  en, in_valid, k, a_re, a_im, b_re, b_im, ovf_clr,
    output out_valid, sum_re, sum_im, dif_re, dif_im, sat, ovf_sticky
  );
endinterface

// File: rtl/fft8_bfly_twiddle.sv
// Three-stage radix-2 butterfly: add/sub, W8^k rotation, 1/sqrt(2) scaling with
// round-half-up, then saturation to W bits with per-sample and sticky overflow.
module fft8_bfly_twiddle #(
  parameter int W  = 16,
  parameter int CF = 15
) (
  input logic                clk,
  input logic                rst,
  fft8_bfly_twiddle_if.slave bus
);

  localparam int PW    = W + CF + 3;
  localparam int C_INT = $rtoi($itor(2 ** CF) * 0.7071067811865476 + 0.5);
  localparam logic signed [PW-1:0] C_EXT = PW'(C_INT);
  localparam logic signed [PW-1:0] ROUND = PW'(1) << (CF - 1);
  localparam logic signed [PW-1:0] MAXV  = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV  = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  function automatic logic signed [PW-1:0] scale(input logic signed [W+1:0] x,
                                                 input logic scl);
    logic signed [PW-1:0] prod;
    prod = PW'(x) * C_EXT;
    if (scl) return (prod + ROUND) >>> CF;
    return PW'(x);
  endfunction

  // MSB of the result is the clip flag, the rest is the clamped value.
  function automatic logic [W:0] clip(input logic signed [PW-1:0] v);
    if (v > MAXV) return {1'b1, MAXV[W-1:0]};
    if (v < MINV) return {1'b1, MINV[W-1:0]};
    return {1'b0, v[W-1:0]};
  endfunction

  logic                s1_valid;
  logic [1:0]          s1_k;
  logic signed [W:0]   s1_sr, s1_si, s1_dr, s1_di;
  logic                s2_valid;
  logic                s2_scl;
  logic signed [W+1:0] s2_xr, s2_xi;
  logic signed [W:0]   s2_sr, s2_si;

  logic signed [W:0]   sr_c, si_c, dr_c, di_c;
  logic signed [W+1:0] dr2, di2, xr_c, xi_c;
  logic                scl_c;
  logic [W:0]          c_sr, c_si, c_dr, c_di;
  logic                sticky_set;

  always_comb begin
    sr_c = (W+1)'(bus.a_re) + (W+1)'(bus.b_re);
    si_c = (W+1)'(bus.a_im) + (W+1)'(bus.b_im);
    dr_c = (W+1)'(bus.a_re) - (W+1)'(bus.b_re);
    di_c = (W+1)'(bus.a_im) - (W+1)'(bus.b_im);
  end

  // Odd k rotations land on the diagonal and need the 1/sqrt(2) scale later.
  always_comb begin
    dr2   = (W+2)'(s1_dr);
    di2   = (W+2)'(s1_di);
    xr_c  = dr2;
    xi_c  = di2;
    scl_c = 1'b0;
    case (s1_k)
      2'd1: begin
        xr_c  = dr2 + di2;
        xi_c  = di2 - dr2;
        scl_c = 1'b1;
      end
      2'd2: begin
        xr_c = di2;
        xi_c = -dr2;
      end
      2'd3: begin
        xr_c  = di2 - dr2;
        xi_c  = -(dr2 + di2);
        scl_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    c_sr       = clip(PW'(s2_sr));
    c_si       = clip(PW'(s2_si));
    c_dr       = clip(scale(s2_xr, s2_scl));
    c_di       = clip(scale(s2_xi, s2_scl));
    sticky_set = bus.en & bus.out_valid & bus.sat;
  end

  // The sticky flag keeps listening to ovf_clr while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_k           <= '0;
      s1_sr          <= '0;
      s1_si          <= '0;
      s1_dr          <= '0;
      s1_di          <= '0;
      s2_valid       <= 1'b0;
      s2_scl         <= 1'b0;
      s2_xr          <= '0;
      s2_xi          <= '0;
      s2_sr          <= '0;
      s2_si          <= '0;
      bus.out_valid  <= 1'b0;
      bus.sum_re     <= '0;
      bus.sum_im     <= '0;
      bus.dif_re     <= '0;
      bus.dif_im     <= '0;
      bus.sat        <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      if (bus.en) begin
        s1_valid      <= bus.in_valid;
        s1_k          <= bus.k;
        s1_sr         <= sr_c;
        s1_si         <= si_c;
        s1_dr         <= dr_c;
        s1_di         <= di_c;
        s2_valid      <= s1_valid;
        s2_scl        <= scl_c;
        s2_xr         <= xr_c;
        s2_xi         <= xi_c;
        s2_sr         <= s1_sr;
        s2_si         <= s1_si;
        bus.out_valid <= s2_valid;
        bus.sum_re    <= c_sr[W-1:0];
        bus.sum_im    <= c_si[W-1:0];
        bus.dif_re    <= c_dr[W-1:0];
        bus.dif_im    <= c_di[W-1:0];
        bus.sat       <= s2_valid & (c_sr[W] | c_si[W] | c_dr[W] | c_di[W]);
      end
      if (bus.ovf_clr) bus.ovf_sticky <= sticky_set;
      else if (sticky_set) bus.ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft8_bfly_twiddle.sv
// Directed bench for fft8_bfly_twiddle: rotation, saturation, sticky clear,
// stall, mid-stream reset and invalid gaps with hand-computed results.
module tb_fft8_bfly_twiddle;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft8_bfly_twiddle_if #(.W(W)) bus ();

  fft8_bfly_twiddle #(.W(W), .CF(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int st_are[5] = '{1000, -500, 0, 12000, -100};
  int st_aim[5] = '{-2000, 250, 0, -8000, 300};
  int st_bre[5] = '{300, 100, 7, -4000, 50};
  int st_bim[5] = '{400, -50, 3, 6000, -100};
  int st_k[5]   = '{0, 1, 2, 3, 1};
  int e_sre[5]  = '{1300, -400, 7, 8000, -50};
  int e_sim[5]  = '{-1600, 200, 3, -2000, 200};
  int e_dre[5]  = '{700, -212, -3, -21213, 177};
  int e_dim[5]  = '{-2400, 636, 7, -1414, 389};
  int rot_dre[4] = '{80, 99, 60, -14};
  int rot_dim[4] = '{60, -14, -80, -99};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input int kk, input int are,
                                input int aim, input int bre, input int bim);
    bus.in_valid = v;
    bus.k        = 2'(kk);
    bus.a_re     = W'(are);
    bus.a_im     = W'(aim);
    bus.b_re     = W'(bre);
    bus.b_im     = W'(bim);
  endtask

  task automatic apply_sample(input int i);
    apply_stimulus(1'b1, st_k[i], st_are[i], st_aim[i], st_bre[i], st_bim[i]);
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_output(input string tag, input int v, input int sre,
                              input int sim, input int dre, input int dim,
                              input int s);
    chk({tag, ".out_valid"}, int'(bus.out_valid), v);
    chk({tag, ".sum_re"}, int'(bus.sum_re), sre);
    chk({tag, ".sum_im"}, int'(bus.sum_im), sim);
    chk({tag, ".dif_re"}, int'(bus.dif_re), dre);
    chk({tag, ".dif_im"}, int'(bus.dif_im), dim);
    chk({tag, ".sat"}, int'(bus.sat), s);
  endtask

  task automatic check_sample(input string tag, input int i);
    check_output(tag, 1, e_sre[i], e_sim[i], e_dre[i], e_dim[i], 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.ovf_clr = 1'b0;
    apply_stimulus(1'b1, 0, 32767, 0, 32767, 0);
    tick();
    tick();
    check_output("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.sticky", int'(bus.ovf_sticky), 0);
    rst = 1'b0;

    // Rotation: same operands, back-to-back twiddles 0..3
    for (int i = 0; i < 7; i++) begin
      if (i < 4) apply_stimulus(1'b1, i, 100, 50, 20, -10);
      else apply_stimulus(1'b0, 0, 0, 0, 0, 0);
      tick();
      if (i >= 2 && i < 6)
        check_output($sformatf("rot_k%0d", i - 2), 1, 120, 40,
                     rot_dre[i-2], rot_dim[i-2], 0);
      if (i == 6) chk("rot_tail.out_valid", int'(bus.out_valid), 0);
    end
    chk("rot.sticky", int'(bus.ovf_sticky), 0);

    // Saturation on sum (k=0) then on rotated difference (k=2)
    apply_stimulus(1'b1, 0, 32767, 0, 32767, 0);
    tick();
    apply_stimulus(1'b1, 2, -32768, 0, 32767, 0);
    tick();
    apply_stimulus(1'b0, 0, 0, 0, 0, 0);
    tick();
    check_output("satA", 1, 32767, 0, 0, 0, 1);
    tick();
    check_output("satB", 1, -1, 0, 0, 32767, 1);
    chk("satB.sticky", int'(bus.ovf_sticky), 1);
    tick();
    chk("sat_tail.out_valid", int'(bus.out_valid), 0);
    chk("sat_tail.sat", int'(bus.sat), 0);
    chk("sat_tail.sticky", int'(bus.ovf_sticky), 1);

    // Sticky clear alone, then clear racing a set
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("clr.sticky", int'(bus.ovf_sticky), 0);
    apply_stimulus(1'b1, 0, 32767, 0, 32767, 0);
    tick();
    apply_stimulus(1'b0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("race.sat", int'(bus.sat), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("race.sticky", int'(bus.ovf_sticky), 1);
    bus.en      = 1'b0;
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    bus.en      = 1'b1;
    chk("clr_stalled.sticky", int'(bus.ovf_sticky), 0);

    // Stall mid-stream with junk on the inputs
    for (int i = 0; i < 3; i++) begin
      apply_sample(i);
      tick();
    end
    check_sample("stall_pre", 0);
    bus.en = 1'b0;
    apply_stimulus(1'b1, 3, 32767, 32767, -32768, -32768);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_sample($sformatf("stall_hold%0d", i), 0);
    end
    bus.en = 1'b1;
    for (int i = 3; i < 8; i++) begin
      if (i < 5) apply_sample(i);
      else apply_stimulus(1'b0, 0, 0, 0, 0, 0);
      tick();
      if (i < 7) check_sample($sformatf("stall_s%0d", i - 2), i - 2);
      else chk("stall_tail.out_valid", int'(bus.out_valid), 0);
    end
    chk("stall.sticky", int'(bus.ovf_sticky), 0);

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      apply_sample(i);
      tick();
    end
    rst = 1'b1;
    apply_stimulus(1'b0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    check_output("rst_mid0", 0, 0, 0, 0, 0, 0);
    apply_sample(4);
    tick();
    chk("rst_mid1.out_valid", int'(bus.out_valid), 0);
    apply_stimulus(1'b0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_mid2.out_valid", int'(bus.out_valid), 0);
    tick();
    check_sample("rst_new", 4);
    tick();
    chk("rst_tail.out_valid", int'(bus.out_valid), 0);

    // Alternating valid/invalid, invalid slots carry saturating data
    for (int i = 0; i < 10; i++) begin
      if (i < 8 && (i % 2) == 0) apply_sample(0);
      else if (i < 8) apply_stimulus(1'b0, 0, 32767, 32767, 32767, 32767);
      else apply_stimulus(1'b0, 0, 0, 0, 0, 0);
      tick();
      if (i >= 2) begin
        chk($sformatf("gap%0d.out_valid", i - 2), int'(bus.out_valid),
            ((i - 2) % 2 == 0) ? 1 : 0);
        chk($sformatf("gap%0d.sat", i - 2), int'(bus.sat), 0);
        if ((i - 2) % 2 == 0)
          chk($sformatf("gap%0d.dif_re", i - 2), int'(bus.dif_re), e_dre[0]);
      end
    end
    tick();
    chk("gap.sticky", int'(bus.ovf_sticky), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft8_bfly_twiddle.md
# fft8_bfly_twiddle

Pipelined, parametrised radix-2 complex butterfly for the 8-point FFT datapath. It computes a+b and (a−b)·W8^k with a per-sample twiddle select k∈{0..3}. The 1/√2 scaling is a rounded constant multiply. Outputs are saturated to the input width with per-sample and sticky overflow flags. It sits between FFT stages, accepts one complex pair per enabled cycle, and has a fixed 3-stage latency.

## Interface
- W, 16, component width (signed two's complement) of all data ports
- CF, 15, fraction bits of 1/√2 constant; C = round(2^CF/√2) (23170 for CF=15)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global pipeline enable; 0 freezes every stage register and flag
- in_valid  in  1  input sample qualifier
- k  in  2  twiddle index, sampled with in_valid
- a_re, a_im, b_re, b_im  in  W each  input operands
- ovf_clr  in  1  clears ovf_sticky
- out_valid  out  1  output qualifier
- sum_re, sum_im, dif_re, dif_im  out  W each  results
- sat  out  1  any of the four results clipped this sample (valid with out_valid)
- ovf_sticky  out  1  latched OR of sat since last clear

## Operation
- Stage 1 (W+1 bits): sr=a_re+b_re, si=a_im+b_im, dr=a_re−b_re, di=a_im−b_im; register k and valid.
- Stage 2 rotation (W+2 bits), scl flag:
  - k=0: (dr, di), scl=0
  - k=1: (dr+di, di−dr), scl=1
  - k=2: (di, −dr), scl=0
  - k=3: (di−dr, −(dr+di)), scl=1
  - sum path passed through delay-matched.
- Stage 3: if scl, y=(x·C + 2^(CF−1)) >>> CF (arithmetic shift, round half up); else y=x. Every result (sum and dif) saturated to [−2^(W−1), 2^(W−1)−1]. sat = OR of the four clip events, gated by stage-3 valid.
- Intermediate products are wide enough that no internal wrap occurs: W+2+CF+1 bits.
- ovf_sticky: set on cycle where out_valid&sat is registered; cleared by ovf_clr; set wins over ovf_clr on the same cycle.
- Invalid samples still propagate data but out_valid=0 and sat=0 for them; ovf_sticky is not affected.

## Timing
- Reset (rst=1 at posedge, regardless of en): all stage valids, out_valid, sat, ovf_sticky and all data outputs = 0. Samples in flight are discarded; no partial output after reset.
- Latency: sample accepted at edge t (in_valid=1, en=1) appears at edge t+3 with out_valid=1, given en=1 on all three edges.
- Throughput: 1 sample/cycle; back-to-back in_valid allowed; no backpressure beyond en.
- en=0: all registers hold, including out_valid, so an output stays presented; inputs ignored. ovf_clr is still honoured when en=0.
- k is captured only with the sample; changing k in later cycles does not affect samples already in flight.

## Test plan
- Rotation, W=16: a=(100,50), b=(20,−10), back-to-back k=0,1,2,3 → sum=(120,40) every sample; dif=(80,60), (99,−14), (60,−80), (−14,−99) on 4 consecutive cycles, starting 3 cycles after first input; sat=0.
- Saturation: a=(32767,0), b=(32767,0), k=0 → sum=(32767,0), dif=(0,0), sat=1, ovf_sticky=1 next cycle. Then a=(−32768,0), b=(32767,0), k=2 → dif=(0,32767), sat=1.
- Sticky clear: after ovf_sticky=1, pulse ovf_clr with no saturating sample → 0. Pulse ovf_clr on the same edge as a saturating out_valid → remains 1.
- Stall: stream 5 samples, drop en for 4 cycles mid-stream → outputs frozen during stall; all 5 results correct and in order; no duplicates or drops.
- Reset mid-operation: rst for 1 cycle with 3 samples in flight → out_valid=0, outputs 0 for next 3 cycles. The next new sample emerges exactly 3 cycles after acceptance.
- Invalid gaps: alternating in_valid=1/0 with saturating data on invalid slots → out_valid alternates; sat and ovf_sticky stay 0.
